// File: rtl/llc_snoop_responder.sv
// llc_snoop_responder
//   Bus-side snoop responder for the 16-way, 64 B-line LLC. It accepts one
//   snooped bus operation at a time and looks up the addressed set in the tag/MESI
//   store. It answers NOHIT/HIT/HITM. When the hit line is modified, it fetches the
//   line from L1, writes it back on the bus, optionally invalidates the L1 copy and
//   finally rewrites the MESI state of the hit way. PLRU state is never touched.
//
// Ports
//   clk, rst_n                         clock, asynchronous active-low reset
//   snp_valid/snp_ready/snp_op/snp_addr  snoop request (READ/WRITE/RWIM/INVALIDATE)
//   snp_rsp_valid/snp_rsp              one-cycle response strobe (NOHIT/HIT/HITM)
//   ts_rd_en/ts_rd_set                 tag store read request
//   ts_rd_tags/ts_rd_mesi              tag store read data, valid the cycle after ts_rd_en
//   ts_wr_en/ts_wr_set/ts_wr_way/ts_wr_mesi  tag store MESI write
//   l1_msg_valid/l1_msg_ready/l1_msg/l1_msg_addr  L1 message channel (GETLINE/INVALIDATELINE)
//   wb_valid/wb_ready/wb_addr          bus writeback of the modified line
//   err                                one-cycle protocol-violation strobe
//   cnt_hit/cnt_hitm                   saturating HIT / HITM response counters
module llc_snoop_responder #(
    parameter int  ADDR_SIZE   = 32,
    parameter int  LINE_SIZE   = 64,
    parameter int  N_WAY       = 16,
    parameter int  NUM_SETS    = 16384,
    localparam int OFFSET_SIZE = $clog2(LINE_SIZE),
    localparam int INDEX_SIZE  = $clog2(NUM_SETS),
    localparam int TAG_SIZE    = ADDR_SIZE - INDEX_SIZE - OFFSET_SIZE,
    localparam int WAY_BITS    = $clog2(N_WAY)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      snp_valid,
    output logic                      snp_ready,
    input  logic [1:0]                snp_op,
    input  logic [ADDR_SIZE-1:0]      snp_addr,
    output logic                      snp_rsp_valid,
    output logic [1:0]                snp_rsp,
    output logic                      ts_rd_en,
    output logic [INDEX_SIZE-1:0]     ts_rd_set,
    input  logic [N_WAY*TAG_SIZE-1:0] ts_rd_tags,
    input  logic [N_WAY*2-1:0]        ts_rd_mesi,
    output logic                      ts_wr_en,
    output logic [INDEX_SIZE-1:0]     ts_wr_set,
    output logic [WAY_BITS-1:0]       ts_wr_way,
    output logic [1:0]                ts_wr_mesi,
    output logic                      l1_msg_valid,
    input  logic                      l1_msg_ready,
    output logic [1:0]                l1_msg,
    output logic [ADDR_SIZE-1:0]      l1_msg_addr,
    output logic                      wb_valid,
    input  logic                      wb_ready,
    output logic [ADDR_SIZE-1:0]      wb_addr,
    output logic                      err,
    output logic [31:0]               cnt_hit,
    output logic [31:0]               cnt_hitm
);

    typedef enum logic [2:0] {IDLE, LOOKUP, RESP, GETL, WB, INVL, UPDATE} state_e;
    typedef enum logic [1:0] {OP_READ, OP_WRITE, OP_RWIM, OP_INVALIDATE} op_e;
    typedef enum logic [1:0] {MESI_M, MESI_E, MESI_S, MESI_I} mesi_e;
    typedef enum logic [1:0] {RSP_NOHIT, RSP_HIT, RSP_HITM} rsp_e;
    typedef enum logic [1:0] {L1_GETLINE, L1_INVALIDATELINE} l1_msg_e;

    state_e                state, state_d;
    op_e                   lat_op;
    logic [TAG_SIZE-1:0]   lat_tag;
    logic [INDEX_SIZE-1:0] lat_set;
    logic [WAY_BITS-1:0]   lat_way;
    mesi_e                 lat_mesi;

    logic [N_WAY-1:0]      match;
    logic                  hit, multi_hit;
    logic [WAY_BITS-1:0]   hit_way;
    mesi_e                 hit_mesi;
    rsp_e                  rsp;
    mesi_e                 new_mesi;
    logic                  act_err;
    state_e                resp_next;

    // Only line-granular addresses are tracked; the byte offset is dropped.
    logic unused_offset;
    assign unused_offset = ^snp_addr[OFFSET_SIZE-1:0];

    assign ts_rd_set   = lat_set;
    assign ts_wr_set   = lat_set;
    assign ts_wr_way   = lat_way;
    assign ts_wr_mesi  = lat_mesi;
    assign l1_msg_addr = {lat_tag, lat_set, {OFFSET_SIZE{1'b0}}};
    assign wb_addr     = {lat_tag, lat_set, {OFFSET_SIZE{1'b0}}};

    // Tag compare across all valid (non-I) ways.
    always_comb begin
        match = '0;
        for (int unsigned w = 0; w < N_WAY; w++) begin
            match[w] = (ts_rd_mesi[w*2 +: 2] != MESI_I) &&
                       (ts_rd_tags[w*TAG_SIZE +: TAG_SIZE] == lat_tag);
        end
    end

    assign hit       = |match;
    assign multi_hit = |(match & (match - 1'b1));

    // Walk from the top way downwards so the lowest matching way wins.
    always_comb begin
        hit_way  = '0;
        hit_mesi = MESI_I;
        for (int unsigned i = 0; i < N_WAY; i++) begin
            if (match[N_WAY-1-i]) begin
                hit_way  = WAY_BITS'(N_WAY-1-i);
                hit_mesi = mesi_e'(ts_rd_mesi[(N_WAY-1-i)*2 +: 2]);
            end
        end
    end

    // Response, new MESI state and follow-up sequence for the looked-up line.
    always_comb begin
        rsp       = RSP_NOHIT;
        new_mesi  = hit_mesi;
        act_err   = 1'b0;
        resp_next = IDLE;
        if (hit) begin
            case (lat_op)
                OP_READ: begin
                    new_mesi = MESI_S;
                    case (hit_mesi)
                        MESI_M: begin
                            rsp       = RSP_HITM;
                            resp_next = GETL;
                        end
                        MESI_E: begin
                            rsp       = RSP_HIT;
                            resp_next = UPDATE;
                        end
                        default: rsp = RSP_HIT;
                    endcase
                end
                OP_WRITE: act_err = 1'b1;
                OP_RWIM: begin
                    new_mesi = MESI_I;
                    if (hit_mesi == MESI_M) begin
                        rsp       = RSP_HITM;
                        resp_next = GETL;
                    end else begin
                        rsp       = RSP_HIT;
                        resp_next = INVL;
                    end
                end
                default: begin
                    if (hit_mesi == MESI_S) begin
                        rsp       = RSP_HIT;
                        new_mesi  = MESI_I;
                        resp_next = INVL;
                    end else begin
                        act_err = 1'b1;
                    end
                end
            endcase
        end
    end

    always_comb begin
        state_d       = state;
        snp_ready     = 1'b0;
        snp_rsp_valid = 1'b0;
        snp_rsp       = RSP_NOHIT;
        ts_rd_en      = 1'b0;
        ts_wr_en      = 1'b0;
        l1_msg_valid  = 1'b0;
        l1_msg        = L1_GETLINE;
        wb_valid      = 1'b0;
        err           = 1'b0;
        case (state)
            IDLE: begin
                // Reset leaves the FSM in IDLE; ready must still read low then.
                snp_ready = rst_n;
                if (snp_valid) state_d = LOOKUP;
            end
            LOOKUP: begin
                ts_rd_en = 1'b1;
                state_d  = RESP;
            end
            RESP: begin
                snp_rsp_valid = 1'b1;
                snp_rsp       = rsp;
                err           = act_err | multi_hit;
                state_d       = resp_next;
            end
            GETL: begin
                l1_msg_valid = 1'b1;
                if (l1_msg_ready) state_d = WB;
            end
            WB: begin
                wb_valid = 1'b1;
                if (wb_ready) state_d = (lat_op == OP_RWIM) ? INVL : UPDATE;
            end
            INVL: begin
                l1_msg_valid = 1'b1;
                l1_msg       = L1_INVALIDATELINE;
                if (l1_msg_ready) state_d = UPDATE;
            end
            UPDATE: begin
                ts_wr_en = 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            lat_op   <= OP_READ;
            lat_tag  <= '0;
            lat_set  <= '0;
            lat_way  <= '0;
            lat_mesi <= MESI_M;
            cnt_hit  <= '0;
            cnt_hitm <= '0;
        end else begin
            state <= state_d;
            if (state == IDLE && snp_valid) begin
                lat_op  <= op_e'(snp_op);
                lat_tag <= snp_addr[ADDR_SIZE-1 -: TAG_SIZE];
                lat_set <= snp_addr[OFFSET_SIZE +: INDEX_SIZE];
            end
            if (state == RESP) begin
                lat_way  <= hit_way;
                lat_mesi <= new_mesi;
                if (rsp == RSP_HIT && cnt_hit != '1) cnt_hit <= cnt_hit + 32'd1;
                if (rsp == RSP_HITM && cnt_hitm != '1) cnt_hitm <= cnt_hitm + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_llc_snoop_responder.sv
module tb_llc_snoop_responder;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         snp_valid;
    logic         snp_ready;
    logic [1:0]   snp_op;
    logic [31:0]  snp_addr;
    logic         snp_rsp_valid;
    logic [1:0]   snp_rsp;
    logic         ts_rd_en;
    logic [13:0]  ts_rd_set;
    logic [191:0] ts_rd_tags = '0;
    logic [31:0]  ts_rd_mesi = '0;
    logic         ts_wr_en;
    logic [13:0]  ts_wr_set;
    logic [3:0]   ts_wr_way;
    logic [1:0]   ts_wr_mesi;
    logic         l1_msg_valid;
    logic         l1_msg_ready = 1'b0;
    logic [1:0]   l1_msg;
    logic [31:0]  l1_msg_addr;
    logic         wb_valid;
    logic         wb_ready = 1'b0;
    logic [31:0]  wb_addr;
    logic         err;
    logic [31:0]  cnt_hit;
    logic [31:0]  cnt_hitm;

    always #5 clk = ~clk;

    llc_snoop_responder dut (
        .clk(clk), .rst_n(rst_n),
        .snp_valid(snp_valid), .snp_ready(snp_ready), .snp_op(snp_op), .snp_addr(snp_addr),
        .snp_rsp_valid(snp_rsp_valid), .snp_rsp(snp_rsp),
        .ts_rd_en(ts_rd_en), .ts_rd_set(ts_rd_set), .ts_rd_tags(ts_rd_tags), .ts_rd_mesi(ts_rd_mesi),
        .ts_wr_en(ts_wr_en), .ts_wr_set(ts_wr_set), .ts_wr_way(ts_wr_way), .ts_wr_mesi(ts_wr_mesi),
        .l1_msg_valid(l1_msg_valid), .l1_msg_ready(l1_msg_ready), .l1_msg(l1_msg),
        .l1_msg_addr(l1_msg_addr),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_addr(wb_addr),
        .err(err), .cnt_hit(cnt_hit), .cnt_hitm(cnt_hitm)
    );

    // kind: 0=GETLINE 1=WRITEBACK 2=INVALIDATELINE 3=TAG WRITE 7=bad L1 code
    typedef struct packed {
        logic [2:0]  kind;
        logic [31:0] addr;
        logic [3:0]  way;
        logic [1:0]  mesi;
    } ev_t;

    int n_checks = 0;
    int n_fail   = 0;

    // Contents of the set the bench presents to the responder.
    logic [11:0] mem_tag[16];
    logic [1:0]  mem_mesi[16];

    ev_t exp_q[$];
    ev_t act_q[$];

    int          cyc = 0;
    int          rd_cnt, rsp_cnt, err_cnt, stab_err, rsp_cyc, acc_cyc, done_cyc;
    logic [1:0]  rsp_val;
    logic [13:0] rd_set_seen;
    int          l1_delay = 0, wb_delay = 0, l1_seen = 0, wb_seen = 0;
    bit          rnd_ready = 0;
    bit          rd_seen = 0;
    bit          prev_l1_wait = 0, prev_wb_wait = 0;
    logic [1:0]  prev_l1_msg;
    logic [31:0] prev_l1_addr, prev_wb_addr;
    logic [31:0] exp_hit = 0, exp_hitm = 0;

    function automatic ev_t mk_ev(input logic [2:0] k, input logic [31:0] a,
                                  input logic [3:0] w, input logic [1:0] m);
        ev_t e;
        e.kind = k; e.addr = a; e.way = w; e.mesi = m;
        return e;
    endfunction

    // Tag store read data appears only in the cycle after a read strobe; otherwise junk.
    always @(posedge clk) begin
        cyc++;
        #1;
        if (rd_seen) begin
            for (int w = 0; w < 16; w++) begin
                ts_rd_tags[w*12 +: 12] = mem_tag[w];
                ts_rd_mesi[w*2 +: 2]   = mem_mesi[w];
            end
        end else begin
            ts_rd_tags = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
            ts_rd_mesi = $urandom();
        end
        l1_msg_ready = rnd_ready ? ($urandom_range(0, 2) == 0) : (l1_seen >= l1_delay);
        wb_ready     = rnd_ready ? ($urandom_range(0, 2) == 0) : (wb_seen >= wb_delay);
    end

    // Passive monitor: records handshakes and tag writes, counts strobes and stability slips.
    always @(negedge clk) begin
        rd_seen = ts_rd_en;
        if (ts_rd_en) begin rd_cnt++; rd_set_seen = ts_rd_set; end
        if (snp_rsp_valid) begin rsp_cnt++; rsp_cyc = cyc; rsp_val = snp_rsp; end
        if (err) err_cnt++;
        if (prev_l1_wait && (!l1_msg_valid || l1_msg !== prev_l1_msg || l1_msg_addr !== prev_l1_addr))
            stab_err++;
        if (prev_wb_wait && (!wb_valid || wb_addr !== prev_wb_addr))
            stab_err++;
        if (l1_msg_valid) begin
            if (l1_msg_ready) begin
                act_q.push_back(mk_ev((l1_msg == 2'd0) ? 3'd0 : (l1_msg == 2'd1) ? 3'd2 : 3'd7,
                                      l1_msg_addr, 4'd0, 2'd0));
                l1_seen = 0;
            end else l1_seen++;
        end
        if (wb_valid) begin
            if (wb_ready) begin
                act_q.push_back(mk_ev(3'd1, wb_addr, 4'd0, 2'd0));
                wb_seen = 0;
            end else wb_seen++;
        end
        if (ts_wr_en) act_q.push_back(mk_ev(3'd3, {18'd0, ts_wr_set}, ts_wr_way, ts_wr_mesi));
        prev_l1_wait = l1_msg_valid && !l1_msg_ready;
        prev_l1_msg  = l1_msg;
        prev_l1_addr = l1_msg_addr;
        prev_wb_wait = wb_valid && !wb_ready;
        prev_wb_addr = wb_addr;
    end

    // Reference: the snoop action table applied to the presented set contents.
    task automatic model(input logic [1:0] op, input logic [31:0] addr,
                         output logic [1:0] rsp, output bit e_err);
        logic [11:0] tag = addr[31:20];
        logic [31:0] la  = {addr[31:6], 6'd0};
        logic [31:0] sa  = {18'd0, addr[19:6]};
        int hits = 0, way = -1;
        logic [1:0] st;
        for (int w = 0; w < 16; w++)
            if (mem_mesi[w] != 2'd3 && mem_tag[w] == tag) begin
                hits++;
                if (way < 0) way = w;
            end
        e_err = (hits > 1);
        rsp = 2'd0;
        exp_q.delete();
        if (way >= 0) begin
            st = mem_mesi[way];
            case (op)
                2'd0: if (st == 2'd0) begin
                          rsp = 2'd2;
                          exp_q.push_back(mk_ev(3'd0, la, 4'd0, 2'd0));
                          exp_q.push_back(mk_ev(3'd1, la, 4'd0, 2'd0));
                          exp_q.push_back(mk_ev(3'd3, sa, 4'(way), 2'd2));
                      end else begin
                          rsp = 2'd1;
                          if (st == 2'd1) exp_q.push_back(mk_ev(3'd3, sa, 4'(way), 2'd2));
                      end
                2'd1: e_err = 1;
                2'd2: begin
                          if (st == 2'd0) begin
                              rsp = 2'd2;
                              exp_q.push_back(mk_ev(3'd0, la, 4'd0, 2'd0));
                              exp_q.push_back(mk_ev(3'd1, la, 4'd0, 2'd0));
                          end else rsp = 2'd1;
                          exp_q.push_back(mk_ev(3'd2, la, 4'd0, 2'd0));
                          exp_q.push_back(mk_ev(3'd3, sa, 4'(way), 2'd3));
                      end
                default: if (st == 2'd2) begin
                          rsp = 2'd1;
                          exp_q.push_back(mk_ev(3'd2, la, 4'd0, 2'd0));
                          exp_q.push_back(mk_ev(3'd3, sa, 4'(way), 2'd3));
                      end else e_err = 1;
            endcase
        end
        if (rsp == 2'd1) exp_hit++;
        if (rsp == 2'd2) exp_hitm++;
    endtask

    task automatic fill_set(input logic [11:0] avoid);
        for (int w = 0; w < 16; w++) begin
            do mem_tag[w] = 12'($urandom()); while (mem_tag[w] == avoid);
            mem_mesi[w] = 2'($urandom());
        end
    endtask

    task automatic run_snoop(input string name, input logic [1:0] op, input logic [31:0] addr);
        logic [1:0] e_rsp;
        bit e_err, acc = 0, done = 0;
        @(posedge clk); #2;
        act_q.delete();
        rd_cnt = 0; rsp_cnt = 0; err_cnt = 0; stab_err = 0; rsp_cyc = -1; done_cyc = -1;
        model(op, addr, e_rsp, e_err);
        snp_valid = 1'b1; snp_op = op; snp_addr = addr;
        for (int i = 0; i < 20 && !acc; i++) begin
            @(negedge clk);
            if (snp_ready) begin acc = 1; acc_cyc = cyc; end
        end
        @(posedge clk); #2;
        snp_valid = 1'b0; snp_op = 2'($urandom()); snp_addr = $urandom();
        n_checks++;
        if (!acc) begin
            n_fail++; $display("FAIL %s accept: snp_ready never seen, required within 20 cycles", name);
            return;
        end
        for (int i = 0; i < 300 && !done; i++) begin
            @(negedge clk);
            if (cyc - acc_cyc <= 2) begin
                n_checks++;
                if (snp_ready !== 1'b0) begin
                    n_fail++; $display("FAIL %s busy_ready: got %b required 0", name, snp_ready);
                end
            end else if (snp_ready) begin done = 1; done_cyc = cyc; end
        end
        #1;
        n_checks++;
        if (!done) begin n_fail++; $display("FAIL %s done: no return to idle in 300 cycles", name); end
        n_checks++;
        if (rd_cnt !== 1) begin n_fail++; $display("FAIL %s rd_count: got %0d required 1", name, rd_cnt); end
        n_checks++;
        if (rd_set_seen !== addr[19:6]) begin
            n_fail++; $display("FAIL %s rd_set: got %h required %h", name, rd_set_seen, addr[19:6]);
        end
        n_checks++;
        if (rsp_cnt !== 1) begin n_fail++; $display("FAIL %s rsp_count: got %0d required 1", name, rsp_cnt); end
        n_checks++;
        if (rsp_cyc - acc_cyc !== 2) begin
            n_fail++; $display("FAIL %s rsp_latency: got %0d required 2", name, rsp_cyc - acc_cyc);
        end
        n_checks++;
        if (rsp_val !== e_rsp) begin n_fail++; $display("FAIL %s rsp: got %0d required %0d", name, rsp_val, e_rsp); end
        n_checks++;
        if (err_cnt !== int'(e_err)) begin
            n_fail++; $display("FAIL %s err_pulses: got %0d required %0d", name, err_cnt, e_err);
        end
        n_checks++;
        if (act_q.size() !== exp_q.size()) begin
            n_fail++; $display("FAIL %s event_count: got %0d required %0d", name, act_q.size(), exp_q.size());
        end
        for (int i = 0; i < act_q.size() && i < exp_q.size(); i++) begin
            n_checks++;
            if (act_q[i] !== exp_q[i]) begin
                n_fail++; $display("FAIL %s event%0d: got %h required %h", name, i, act_q[i], exp_q[i]);
            end
        end
        n_checks++;
        if (stab_err !== 0) begin n_fail++; $display("FAIL %s hold_stable: got %0d slips required 0", name, stab_err); end
        n_checks++;
        if (cnt_hit !== exp_hit || cnt_hitm !== exp_hitm) begin
            n_fail++; $display("FAIL %s counters: got %0d/%0d required %0d/%0d", name, cnt_hit, cnt_hitm, exp_hit, exp_hitm);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({snp_ready, snp_rsp_valid, ts_rd_en, ts_wr_en, l1_msg_valid, wb_valid, err} !== 7'd0) begin
            n_fail++; $display("FAIL reset_strobes: got %b required 0000000",
                {snp_ready, snp_rsp_valid, ts_rd_en, ts_wr_en, l1_msg_valid, wb_valid, err});
        end
        n_checks++;
        if ({cnt_hit, cnt_hitm, l1_msg_addr, wb_addr, ts_rd_set, ts_wr_set} !== '0) begin
            n_fail++; $display("FAIL reset_values: counters/addresses not zero (%h %h %h %h)",
                cnt_hit, cnt_hitm, l1_msg_addr, wb_addr);
        end
        repeat (2) @(negedge clk);
        #2; rst_n = 1'b1; #1;
        n_checks++;
        if (snp_ready !== 1'b1) begin n_fail++; $display("FAIL reset_release_ready: got %b required 1", snp_ready); end
    endtask

    task automatic test_read_m();
        fill_set(12'hABC); mem_tag[5] = 12'hABC; mem_mesi[5] = 2'd0;
        run_snoop("read_m", 2'd0, 32'hABC048C0);
        n_checks++;
        if (cnt_hitm !== 32'd1) begin n_fail++; $display("FAIL read_m_cnt_hitm: got %0d required 1", cnt_hitm); end
    endtask

    task automatic test_rwim_e();
        fill_set(12'hABC); mem_tag[5] = 12'hABC; mem_mesi[5] = 2'd1;
        run_snoop("rwim_e", 2'd2, 32'hABC048C0);
    endtask

    task automatic test_rwim_m_stall();
        fill_set(12'hABC); mem_tag[5] = 12'hABC; mem_mesi[5] = 2'd0;
        l1_delay = 4; wb_delay = 3;
        run_snoop("rwim_m_stall", 2'd2, 32'hABC048C0);
        l1_delay = 0; wb_delay = 0;
    endtask

    task automatic test_read_miss();
        for (int w = 0; w < 16; w++) begin mem_tag[w] = 12'hABC; mem_mesi[w] = 2'd3; end
        run_snoop("read_miss", 2'd0, 32'hABC048C0);
        n_checks++;
        if (done_cyc - acc_cyc !== 3) begin
            n_fail++; $display("FAIL read_miss_ready_again: got %0d cycles required 3", done_cyc - acc_cyc);
        end
    endtask

    task automatic test_protocol_err();
        fill_set(12'hABC); mem_tag[5] = 12'hABC; mem_mesi[5] = 2'd1;
        run_snoop("inval_e", 2'd3, 32'hABC048C0);
        fill_set(12'h3F1); mem_tag[9] = 12'h3F1; mem_mesi[9] = 2'd2;
        run_snoop("write_s", 2'd1, 32'h3F1FFFC4);
    endtask

    task automatic test_multi_hit();
        fill_set(12'h5A5);
        mem_tag[3] = 12'h5A5; mem_mesi[3] = 2'd2;
        mem_tag[11] = 12'h5A5; mem_mesi[11] = 2'd0;
        run_snoop("multi_s_m", 2'd0, 32'h5A500040);
        fill_set(12'h5A5);
        mem_tag[2] = 12'h5A5; mem_mesi[2] = 2'd1;
        mem_tag[7] = 12'h5A5; mem_mesi[7] = 2'd0;
        run_snoop("multi_e_m", 2'd0, 32'h5A5FFFFF);
    endtask

    task automatic test_random();
        logic [11:0] tag;
        logic [13:0] set;
        rnd_ready = 1;
        for (int n = 0; n < 60; n++) begin
            tag = 12'($urandom()); set = 14'($urandom());
            for (int w = 0; w < 16; w++) begin
                mem_tag[w]  = ($urandom_range(0, 3) == 0) ? tag : 12'($urandom());
                mem_mesi[w] = 2'($urandom());
            end
            run_snoop("random", 2'($urandom()), {tag, set, 6'($urandom())});
        end
        rnd_ready = 0;
    endtask

    task automatic test_reset_mid_wb();
        bit acc = 0, seen = 0;
        fill_set(12'hABC); mem_tag[5] = 12'hABC; mem_mesi[5] = 2'd0;
        wb_delay = 1000;
        @(posedge clk); #2;
        snp_valid = 1'b1; snp_op = 2'd0; snp_addr = 32'hABC048C0;
        for (int i = 0; i < 20 && !acc; i++) begin @(negedge clk); if (snp_ready) acc = 1; end
        @(posedge clk); #2; snp_valid = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin @(negedge clk); if (wb_valid) seen = 1; end
        n_checks++;
        if (!seen) begin n_fail++; $display("FAIL rst_wb_reach: wb_valid never seen, required within 50 cycles"); end
        #2; rst_n = 1'b0; #1;
        exp_hit = 0; exp_hitm = 0;
        n_checks++;
        if ({wb_valid, l1_msg_valid, snp_ready, ts_wr_en} !== 4'b0000) begin
            n_fail++; $display("FAIL rst_wb_drop: got %b required 0000", {wb_valid, l1_msg_valid, snp_ready, ts_wr_en});
        end
        n_checks++;
        if (cnt_hit !== exp_hit || cnt_hitm !== exp_hitm) begin
            n_fail++; $display("FAIL rst_wb_counters: got %0d/%0d required 0/0", cnt_hit, cnt_hitm);
        end
        @(negedge clk); #2;
        act_q.delete();
        wb_delay = 0;
        rst_n = 1'b1; #1;
        n_checks++;
        if (snp_ready !== 1'b1) begin n_fail++; $display("FAIL rst_wb_idle: snp_ready got %b required 1", snp_ready); end
        repeat (6) @(negedge clk);
        #1;
        n_checks++;
        if (act_q.size() !== 0) begin
            n_fail++; $display("FAIL rst_wb_quiet: got %0d events after reset required 0", act_q.size());
        end
    endtask

    initial begin
        snp_valid = 1'b0; snp_op = 2'd0; snp_addr = '0;
        for (int w = 0; w < 16; w++) begin mem_tag[w] = '0; mem_mesi[w] = 2'd3; end
        test_reset();
        test_read_m();
        test_rwim_e();
        test_rwim_m_stall();
        test_read_miss();
        test_protocol_err();
        test_multi_hit();
        test_random();
        test_reset_mid_wb();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
